// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and MTHI/MTLO writes.
// Divide datapath is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mthi,
    input  logic         mtlo,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_by_zero
);

    localparam int unsigned W2 = 2 * N;
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W2-1:0] acc_q, acc_d;
    logic [N-1:0]  opnd_q, opnd_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [N-1:0]  lo_q, lo_d;
    logic          neg_res_q, neg_res_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          accept;
    logic          signed_op;
    logic          a_neg, b_neg;
    logic [N-1:0]  abs_a, abs_b;
    logic [N:0]    mul_sum;
    logic [W2-1:0] mul_next;
    logic [W2-1:0] prod_fix;

`ifdef MULDIV_DIV_EN
    logic          is_div_q, is_div_d;
    logic          neg_rem_q, neg_rem_d;
    logic          dbz_pend_q, dbz_pend_d;
    logic [N-1:0]  a_raw_q, a_raw_d;
    logic          dbz_q, dbz_d;
    logic [N:0]    div_shift;
    logic          div_ge;
    logic [N-1:0]  div_diff;
    logic [W2-1:0] div_next;
    logic [N-1:0]  q_fix, r_fix;

    assign accept = start;
`else
    assign accept = start & ~op[1];
`endif

    // Magnitudes and result signs of the incoming operands
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[N-1];
        b_neg     = signed_op & b[N-1];
        abs_a     = a_neg ? (~a + N'(1)) : a;
        abs_b     = b_neg ? (~b + N'(1)) : b;
    end

    // One iteration: shift-add multiply; restoring divide keeps {remainder, quotient} in acc
    always_comb begin
        mul_sum  = {1'b0, acc_q[W2-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : (N+1)'(0));
        mul_next = {mul_sum, acc_q[N-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {acc_q[W2-1:N], acc_q[N-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[N-1:0] - opnd_q;
        div_next  = {(div_ge ? div_diff : div_shift[N-1:0]), acc_q[N-2:0], div_ge};
`endif
    end

    // Sign correction applied in FIX
    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + W2'(1)) : acc_q;
`ifdef MULDIV_DIV_EN
        q_fix = neg_res_q ? (~acc_q[N-1:0] + N'(1)) : acc_q[N-1:0];
        r_fix = neg_rem_q ? (~acc_q[W2-1:N] + N'(1)) : acc_q[W2-1:N];
`endif
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        done_d    = 1'b0;
`ifdef MULDIV_DIV_EN
        is_div_d   = is_div_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        a_raw_d    = a_raw_q;
        dbz_d      = dbz_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    neg_res_d = a_neg ^ b_neg;
                    opnd_d    = abs_a;
                    acc_d     = {N'(0), abs_b};
`ifdef MULDIV_DIV_EN
                    is_div_d   = op[1];
                    neg_rem_d  = a_neg;
                    dbz_pend_d = (b == N'(0));
                    a_raw_d    = a;
                    dbz_d      = 1'b0;
                    if (op[1]) begin
                        opnd_d = abs_b;
                        acc_d  = {N'(0), abs_a};
                    end
`endif
                end else if (!start) begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end

            S_RUN: begin
                acc_d = mul_next;
`ifdef MULDIV_DIV_EN
                if (is_div_q) acc_d = div_next;
`endif
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) state_d = S_FIX;
            end

            S_FIX: begin
                hi_d   = prod_fix[W2-1:N];
                lo_d   = prod_fix[N-1:0];
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    if (dbz_pend_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = r_fix;
                        lo_d = q_fix;
                    end
                    dbz_d = dbz_pend_q;
                end
`endif
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef MULDIV_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q   <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            a_raw_q    <= '0;
            dbz_q      <= 1'b0;
        end else begin
            is_div_q   <= is_div_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            a_raw_q    <= a_raw_d;
            dbz_q      <= dbz_d;
        end
    end

    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected HI/LO/div_by_zero per operation.
// Divide scenarios run when MULDIV_DIV_EN is defined; otherwise divide requests must be rejected.
module tb_muldiv_unit;

    localparam int unsigned N = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic [N-1:0] wdata;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         div_by_zero;

    int n_chk  = 0;
    int n_pass = 0;

    logic [64:0]  sb_q[$];
    logic [31:0]  exp_hi;
    logic [31:0]  exp_lo;

    muldiv_unit #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // Reference model: returns {div_by_zero, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] av,
                                          input logic [31:0] bv);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [31:0] sa32;
        logic signed [31:0] sb32;
        logic [63:0]        p;
        logic [31:0]        q;
        logic [31:0]        r;
        sa64 = {{32{av[31]}}, av};
        sb64 = {{32{bv[31]}}, bv};
        sa32 = av;
        sb32 = bv;
        p = '0;
        q = '0;
        r = '0;
        case (o)
            2'b00: p = sa64 * sb64;
            2'b01: p = {32'h0, av} * {32'h0, bv};
            2'b10: begin
                if (bv == 32'h0) return {1'b1, av, 32'hFFFF_FFFF};
                if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
                q = sa32 / sb32;
                r = sa32 % sb32;
                p = {r, q};
            end
            default: begin
                if (bv == 32'h0) return {1'b1, av, 32'hFFFF_FFFF};
                q = av / bv;
                r = av % bv;
                p = {r, q};
            end
        endcase
        return {1'b0, p};
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input bit disturb, input bit with_mt);
        logic [64:0] e;
        int          busy_n;
        bit          seen;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        if (with_mt) begin
            mtlo  = 1'b1;
            wdata = 32'hDEAD_BEEF;
        end
        sb_q.push_back(model(o, av, bv));
        busy_n = 0;
        seen   = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                mtlo  = 1'b0;
                chk("busy_rise", 64'(busy), 64'(1));
                chk("dbz_clear_on_start", 64'(div_by_zero), 64'(0));
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (disturb && k == 3) begin
                start = 1'b1;
                a     = ~av;
                b     = bv + 32'h1;
                op    = ~o;
            end
            if (disturb && k == 4) start = 1'b0;
            if (disturb && k == 5) begin
                mthi  = 1'b1;
                wdata = 32'h5555_AAAA;
            end
            if (disturb && k == 6) mthi = 1'b0;
            if (k == 10) begin
                chk("hi_hold_run", 64'(hi), 64'(exp_hi));
                chk("lo_hold_run", 64'(lo), 64'(exp_lo));
            end
        end
        chk("done_seen", 64'(seen), 64'(1));
        chk("busy_len", 64'(busy_n), 64'(N + 1));
        chk("busy_low_in_done", 64'(busy), 64'(0));
        e = sb_q.pop_front();
        chk("result_hi", 64'(hi), 64'(e[63:32]));
        chk("result_lo", 64'(lo), 64'(e[31:0]));
        chk("result_dbz", 64'(div_by_zero), 64'(e[64]));
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          any_busy;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = '0;
        exp_hi = '0;
        exp_lo = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dbz", 64'(div_by_zero), 64'(0));
        rst_n = 1'b1;

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_max_hi", 64'(exp_hi), 64'(32'hFFFF_FFFE));
        chk("multu_max_lo", 64'(exp_lo), 64'(32'h0000_0001));
        do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);

        @(negedge clk);
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        chk("mthi_write", 64'(hi), 64'(32'hA5A5_A5A5));
        chk("mtlo_write", 64'(lo), 64'(32'hA5A5_A5A5));
        exp_hi = 32'hA5A5_A5A5;
        exp_lo = 32'hA5A5_A5A5;

        do_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        do_op(2'b01, 32'h0001_0003, 32'h0000_FFFF, 1'b0, 1'b1);

`ifdef MULDIV_DIV_EN
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(2'b11, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
        chk("dbz_sticky", 64'(div_by_zero), 64'(1));
        do_op(2'b10, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
        do_op(2'b10, 32'h7654_3210, 32'hFFFF_FF13, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(2'(i), ra, rb, 1'b0, 1'b0);
        end
`else
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start    = 1'b0;
        any_busy = 1'b0;
        repeat (40) begin
            if (busy || done) any_busy = 1'b1;
            @(negedge clk);
        end
        chk("nodiv_never_busy", 64'(any_busy), 64'(0));
        chk("nodiv_hi_kept", 64'(hi), 64'(exp_hi));
        chk("nodiv_lo_kept", 64'(lo), 64'(exp_lo));
        chk("nodiv_dbz", 64'(div_by_zero), 64'(0));
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(2'(i & 1), ra, rb, 1'b0, 1'b0);
        end
`endif

        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'hFFFF_0000;
        b     = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_hi", 64'(hi), 64'(0));
        chk("async_rst_lo", 64'(lo), 64'(0));
        chk("async_rst_done", 64'(done), 64'(0));
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b0);
        chk("after_rst_lo42", 64'(lo), 64'(42));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
